// File: rtl/des_keygen.sv
// des_keygen: DES round counter (cnt 0 = idle, 1..16 = active round) plus
// round-key generator. The subkey is combinational from cnt and the latched key.
// Optional build macro DES_KEYGEN_DECRYPT_EN adds a `decrypt` input that,
// latched at run start, issues subkeys in reverse order (K16 first).
module des_keygen (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [63:0] key,
`ifdef DES_KEYGEN_DECRYPT_EN
    input  logic        decrypt,
`endif
    output logic [4:0]  cnt,
    output logic        cnt_end,
    output logic [47:0] round_key
);

    typedef enum logic {
        IDLE,
        RUN
    } state_e;

    // PC-1: DES key bit numbers (1 = key[63]) feeding C0 then D0
    localparam logic [6:0] PC1_TAB [56] = '{
        7'd57, 7'd49, 7'd41, 7'd33, 7'd25, 7'd17, 7'd9,
        7'd1,  7'd58, 7'd50, 7'd42, 7'd34, 7'd26, 7'd18,
        7'd10, 7'd2,  7'd59, 7'd51, 7'd43, 7'd35, 7'd27,
        7'd19, 7'd11, 7'd3,  7'd60, 7'd52, 7'd44, 7'd36,
        7'd63, 7'd55, 7'd47, 7'd39, 7'd31, 7'd23, 7'd15,
        7'd7,  7'd62, 7'd54, 7'd46, 7'd38, 7'd30, 7'd22,
        7'd14, 7'd6,  7'd61, 7'd53, 7'd45, 7'd37, 7'd29,
        7'd21, 7'd13, 7'd5,  7'd28, 7'd20, 7'd12, 7'd4
    };

    // PC-2: C||D bit numbers (1 = MSB of C) feeding round_key[47] downwards
    localparam logic [5:0] PC2_TAB [48] = '{
        6'd14, 6'd17, 6'd11, 6'd24, 6'd1,  6'd5,
        6'd3,  6'd28, 6'd15, 6'd6,  6'd21, 6'd10,
        6'd23, 6'd19, 6'd12, 6'd4,  6'd26, 6'd8,
        6'd16, 6'd7,  6'd27, 6'd20, 6'd13, 6'd2,
        6'd41, 6'd52, 6'd31, 6'd37, 6'd47, 6'd55,
        6'd30, 6'd40, 6'd51, 6'd45, 6'd33, 6'd48,
        6'd44, 6'd49, 6'd39, 6'd56, 6'd34, 6'd53,
        6'd46, 6'd42, 6'd50, 6'd36, 6'd29, 6'd32
    };

    state_e      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        cnt_end_q, cnt_end_d;
    logic [63:0] key_q, key_d;
`ifdef DES_KEYGEN_DECRYPT_EN
    logic        dec_q, dec_d;
`endif

    logic [4:0]  eff_round;
    logic [4:0]  rot_amt;
    logic [55:0] cd0;
    logic [55:0] c_dbl;
    logic [55:0] d_dbl;
    logic [55:0] cd_r;
    logic [47:0] rk;
    logic        unused_parity;

    // Next-state: start latches key, count 1..16, then back to idle
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        key_d   = key_q;
`ifdef DES_KEYGEN_DECRYPT_EN
        dec_d   = dec_q;
`endif
        if (cnt_q > 5'd16) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_d = RUN;
                        cnt_d   = 5'd1;
                        key_d   = key;
`ifdef DES_KEYGEN_DECRYPT_EN
                        dec_d   = decrypt;
`endif
                    end
                end
                RUN: begin
                    if (cnt_q == 5'd16) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 5'd1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
        cnt_end_d = (cnt_d == 5'd16);
    end

    // State, counter and key latch registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            cnt_end_q <= 1'b0;
            key_q     <= '0;
`ifdef DES_KEYGEN_DECRYPT_EN
            dec_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            cnt_end_q <= cnt_end_d;
            key_q     <= key_d;
`ifdef DES_KEYGEN_DECRYPT_EN
            dec_q     <= dec_d;
`endif
        end
    end

    // Subkey: PC-1, rotate C/D by the cumulative amount for the round, PC-2
    always_comb begin
        cd0 = '0;
        for (int unsigned i = 0; i < 56; i++) begin
            cd0[6'(55 - i)] = key_q[6'(7'd64 - PC1_TAB[6'(i)])];
        end

`ifdef DES_KEYGEN_DECRYPT_EN
        eff_round = dec_q ? (5'd17 - cnt_q) : cnt_q;
`else
        eff_round = cnt_q;
`endif

        case (eff_round)
            5'd1:    rot_amt = 5'd1;
            5'd2:    rot_amt = 5'd2;
            5'd3:    rot_amt = 5'd4;
            5'd4:    rot_amt = 5'd6;
            5'd5:    rot_amt = 5'd8;
            5'd6:    rot_amt = 5'd10;
            5'd7:    rot_amt = 5'd12;
            5'd8:    rot_amt = 5'd14;
            5'd9:    rot_amt = 5'd15;
            5'd10:   rot_amt = 5'd17;
            5'd11:   rot_amt = 5'd19;
            5'd12:   rot_amt = 5'd21;
            5'd13:   rot_amt = 5'd23;
            5'd14:   rot_amt = 5'd25;
            5'd15:   rot_amt = 5'd27;
            5'd16:   rot_amt = 5'd28;
            default: rot_amt = 5'd0;
        endcase

        // Rotate-left via doubled word: upper half of {x,x} << s is rotl(x, s)
        c_dbl = {cd0[55:28], cd0[55:28]} << rot_amt;
        d_dbl = {cd0[27:0],  cd0[27:0]}  << rot_amt;
        cd_r  = {c_dbl[55:28], d_dbl[55:28]};

        rk = '0;
        for (int unsigned i = 0; i < 48; i++) begin
            rk[6'(47 - i)] = cd_r[6'd56 - PC2_TAB[6'(i)]];
        end
    end

    // Parity bits (DES bits 8, 16, ..., 64) never reach the schedule
    always_comb begin
        unused_parity = ^{key_q[56], key_q[48], key_q[40], key_q[32],
                          key_q[24], key_q[16], key_q[8],  key_q[0]};
    end

    // Outputs: registered count, subkey forced to zero outside rounds 1..16
    always_comb begin
        cnt       = cnt_q;
        cnt_end   = cnt_end_q;
        round_key = ((cnt_q == 5'd0) || (cnt_q > 5'd16)) ? '0 : rk;
    end

endmodule

// File: tb/tb_des_keygen.sv
// tb_des_keygen: randomized self-checking bench for des_keygen against an
// iterative (per-round shift) DES key-schedule model.
module tb_des_keygen;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [63:0] key;
    logic        decrypt;
    logic [4:0]  cnt;
    logic        cnt_end;
    logic [47:0] round_key;

    int n_checks = 0;
    int n_errors = 0;

    logic [47:0] exp_ks [1:16];
    logic [47:0] obs_ks [1:16];

    int PC1 [56] = '{57, 49, 41, 33, 25, 17, 9,  1,  58, 50, 42, 34, 26, 18,
                     10, 2,  59, 51, 43, 35, 27, 19, 11, 3,  60, 52, 44, 36,
                     63, 55, 47, 39, 31, 23, 15, 7,  62, 54, 46, 38, 30, 22,
                     14, 6,  61, 53, 45, 37, 29, 21, 13, 5,  28, 20, 12, 4};
    int PC2 [48] = '{14, 17, 11, 24, 1,  5,  3,  28, 15, 6,  21, 10,
                     23, 19, 12, 4,  26, 8,  16, 7,  27, 20, 13, 2,
                     41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
                     44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
    int SHIFT [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    des_keygen dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .key       (key),
`ifdef DES_KEYGEN_DECRYPT_EN
        .decrypt   (decrypt),
`endif
        .cnt       (cnt),
        .cnt_end   (cnt_end),
        .round_key (round_key)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Classic schedule: PC-1, then shift C and D by 1 or 2 per round, PC-2
    task automatic model_sched(input logic [63:0] k);
        logic [27:0] c;
        logic [27:0] d;
        logic [55:0] cd;
        for (int i = 0; i < 28; i++) begin
            c[27-i] = k[64-PC1[i]];
            d[27-i] = k[64-PC1[i+28]];
        end
        for (int r = 1; r <= 16; r++) begin
            for (int s = 0; s < SHIFT[r-1]; s++) begin
                c = {c[26:0], c[27]};
                d = {d[26:0], d[27]};
            end
            cd = {c, d};
            for (int i = 0; i < 48; i++) exp_ks[r][47-i] = cd[56-PC2[i]];
        end
    endtask

    // One start pulse; inputs are scrambled after the first edge to prove latching
    task automatic run_pulse(input logic [63:0] k, input logic dec, input string tag);
        model_sched(k);
        key = k;
        decrypt = dec;
        start = 1'b1;
        for (int r = 1; r <= 16; r++) begin
            tick();
            if (r == 1) begin
                start = 1'b0;
                key = ~k;
                decrypt = ~dec;
            end
            obs_ks[r] = round_key;
            check({tag, ".cnt"}, 64'(cnt), 64'(r));
            check({tag, ".cnt_end"}, 64'(cnt_end), 64'(r == 16));
            check({tag, ".rk"}, 64'(round_key), 64'(exp_ks[dec ? 17 - r : r]));
        end
        tick();
        check({tag, ".end_cnt"}, 64'(cnt), 64'd0);
        check({tag, ".end_cnt_end"}, 64'(cnt_end), 64'd0);
        check({tag, ".end_rk"}, 64'(round_key), 64'd0);
    endtask

    initial begin
        logic [63:0] k;
        logic [63:0] k_new;
        int          expc;

        // Reset held with start high
        rst_n = 1'b0;
        start = 1'b1;
        key = 64'h133457799BBCDFF1;
        decrypt = 1'b0;
        repeat (3) tick();
        check("rst.cnt", 64'(cnt), 64'd0);
        check("rst.cnt_end", 64'(cnt_end), 64'd0);
        check("rst.rk", 64'(round_key), 64'd0);

        // Idle with start low holds at zero
        start = 1'b0;
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("idle.cnt", 64'(cnt), 64'd0);
            check("idle.rk", 64'(round_key), 64'd0);
        end

        // Standard vector
        run_pulse(64'h133457799BBCDFF1, 1'b0, "std");
        check("std.k1", 64'(obs_ks[1]), 64'h1B02EFFC7072);
        check("std.k16", 64'(obs_ks[16]), 64'hCB3D8B0E17F5);

        // Degenerate keys
        run_pulse(64'h0, 1'b0, "zero");
        for (int r = 1; r <= 16; r++) check("zero.const", 64'(obs_ks[r]), 64'd0);
        run_pulse(64'hFFFFFFFFFFFFFFFF, 1'b0, "ones");
        for (int r = 1; r <= 16; r++) check("ones.const", 64'(obs_ks[r]), 64'hFFFFFFFFFFFF);

        // Held start: 17-cycle period
        k = 64'h0E01C00038003808;
        model_sched(k);
        key = k;
        start = 1'b1;
        for (int n = 1; n <= 51; n++) begin
            tick();
            expc = n % 17;
            check("held.cnt", 64'(cnt), 64'(expc));
            check("held.cnt_end", 64'(cnt_end), 64'(expc == 16));
            check("held.rk", 64'(round_key), (expc == 0) ? 64'd0 : 64'(exp_ks[expc]));
        end
        start = 1'b0;

        // Key change at cnt = 5 does not disturb the run
        k = {$urandom, $urandom};
        model_sched(k);
        key = k;
        start = 1'b1;
        for (int r = 1; r <= 16; r++) begin
            tick();
            if (r == 1) start = 1'b0;
            check("mid.cnt", 64'(cnt), 64'(r));
            check("mid.rk", 64'(round_key), 64'(exp_ks[r]));
            if (r == 5) begin
                k_new = {$urandom, $urandom};
                key = k_new;
            end
        end
        tick();
        check("mid.end_cnt", 64'(cnt), 64'd0);

        // Reset asserted at cnt = 9, then start honoured on first edge after release
        k = {$urandom, $urandom};
        key = k;
        start = 1'b1;
        for (int r = 1; r <= 9; r++) begin
            tick();
            if (r == 1) start = 1'b0;
            check("rstmid.cnt", 64'(cnt), 64'(r));
        end
        rst_n = 1'b0;
        #1;
        check("rstmid.cnt0", 64'(cnt), 64'd0);
        check("rstmid.cnt_end0", 64'(cnt_end), 64'd0);
        check("rstmid.rk0", 64'(round_key), 64'd0);
        start = 1'b1;
        tick();
        check("rstmid.hold", 64'(cnt), 64'd0);
        k = {$urandom, $urandom};
        model_sched(k);
        key = k;
        rst_n = 1'b1;
        for (int r = 1; r <= 16; r++) begin
            tick();
            if (r == 1) start = 1'b0;
            check("rstrel.cnt", 64'(cnt), 64'(r));
            check("rstrel.rk", 64'(round_key), 64'(exp_ks[r]));
        end
        tick();
        check("rstrel.end_cnt", 64'(cnt), 64'd0);

        // Random keys
        for (int i = 0; i < 6; i++) begin
            k = {$urandom, $urandom};
`ifdef DES_KEYGEN_DECRYPT_EN
            run_pulse(k, 1'(i % 2), "rand");
`else
            run_pulse(k, 1'b0, "rand");
`endif
        end

`ifdef DES_KEYGEN_DECRYPT_EN
        run_pulse(64'h133457799BBCDFF1, 1'b1, "dec");
        check("dec.first", 64'(obs_ks[1]), 64'hCB3D8B0E17F5);
        check("dec.last", 64'(obs_ks[16]), 64'h1B02EFFC7072);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
